// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Up/down modulo counter (0..MAX) with wrap or saturate mode,
//                overflow pulse, sticky overflow flag and terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter #(
  parameter int unsigned         WIDTH    = 4,
  parameter logic [WIDTH-1:0]    MAX      = {WIDTH{1'b1}},
  parameter int unsigned         SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             at_tc
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic             c_sat  = (SATURATE != 0);

  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..32");
  end
  if (MAX == c_zero) begin : g_bad_max
    $error("updown_mod_counter: MAX must be at least 1");
  end

  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_clamped;

  // Equality tests against MAX cannot overflow even when MAX is all ones.
  assign w_at_max       = (out == MAX);
  assign w_at_zero      = (out == c_zero);
  assign w_load_clamped = (load_val > MAX) ? MAX : load_val;
  assign at_tc          = up ? w_at_max : w_at_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out        <= c_zero;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      out        <= c_zero;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      out <= w_load_clamped;
      ovf <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          out        <= c_sat ? MAX : c_zero;
          ovf        <= 1'b1;
          ovf_sticky <= 1'b1;
        end else begin
          out <= out + c_one;
          ovf <= 1'b0;
        end
      end else begin
        if (w_at_zero) begin
          out        <= c_sat ? c_zero : MAX;
          ovf        <= 1'b1;
          ovf_sticky <= 1'b1;
        end else begin
          out <= out - c_one;
          ovf <= 1'b0;
        end
      end
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire
